// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: issues sequential fetch addresses to the I-cache,
// buffers {pc, insn} pairs in a small FIFO and hands them to decode via valid/ready.
module ifetch_queue #(
    parameter logic [31:0] START_ADDR = 32'h8002_0000,
    parameter int unsigned MEM_BYTES  = 100000,
    parameter int unsigned DEPTH      = 4
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] ic_address,
    input  logic [31:0] ic_data,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_insn,
    output logic [31:0] out_pc,
    output logic        fetch_end
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [32:0] END_ADDR = {1'b0, START_ADDR} + 33'(MEM_BYTES);

    typedef enum logic {
        RUN,
        STALL
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    logic [31:0]     fetch_pc;
    logic [31:0]     redirect_target;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic            full;
    logic            push;
    logic            pop;
    fetch_state_e    fetch_state;

    // The image end is computed in 33 bits so a START_ADDR near the top of memory cannot wrap.
    assign fetch_end       = ({1'b0, fetch_pc} >= END_ADDR) || (fetch_pc < START_ADDR);
    assign ic_address      = fetch_pc;
    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

    assign full      = (count == CW'(DEPTH));
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        fetch_state = STALL;
        if (fetch_en && !fetch_end && (!full || pop)) begin
            fetch_state = RUN;
        end
    end

    // A redirect cycle never pushes, even though the fetch state itself says RUN.
    assign push = (fetch_state == RUN) && !redirect_valid;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc <= START_ADDR;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_target;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + PW'(1);
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // NOTE: the storage array has no reset; the outputs are gated by out_valid instead.
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            mem[wr_ptr] <= '{pc: fetch_pc, insn: ic_data};
        end
    end

    always_comb begin
        head     = mem[rd_ptr];
        out_pc   = '0;
        out_insn = '0;
        if (out_valid) begin
            out_pc   = head.pc;
            out_insn = head.insn;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: a queue-based reference model predicts every
// head entry and fetch address, plus directed checks on the boundary scenarios.
module tb_ifetch_queue;

    localparam logic [31:0] START = 32'h8002_0000;
    localparam int unsigned MEMB  = 100000;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] END_A = START + MEMB;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } entry_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] ic_address;
    logic [31:0] ic_data;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_insn;
    logic [31:0] out_pc;
    logic        fetch_end;

    int          total = 0;
    int          bad   = 0;
    bit          chk_en = 1'b0;
    logic [31:0] m_pc;
    entry_t      sb[$];

    ifetch_queue #(
        .START_ADDR(START),
        .MEM_BYTES (MEMB),
        .DEPTH     (DEPTH)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .ic_address    (ic_address),
        .ic_data       (ic_data),
        .fetch_en      (fetch_en),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_insn      (out_insn),
        .out_pc        (out_pc),
        .fetch_end     (fetch_end)
    );

    always #5 clock = ~clock;

    // Cache model: returns the low half of the address as the instruction word.
    assign ic_data = {16'h0000, ic_address[15:0]};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_end(input logic [31:0] pc);
        return (pc >= END_A) || (pc < START);
    endfunction

    // One clock: compare outputs at the falling edge, then advance the model at the rising edge.
    task automatic cycle();
        logic mend, mpop, mpush;
        @(negedge clock);
        mend = model_end(m_pc);
        if (chk_en) begin
            check("ic_address", ic_address, m_pc);
            check("fetch_end", 32'(fetch_end), 32'(mend));
            check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
            if (sb.size() != 0) begin
                check("out_pc", out_pc, sb[0].pc);
                check("out_insn", out_insn, sb[0].insn);
            end
        end
        mpop  = (sb.size() != 0) && out_ready;
        mpush = fetch_en && !mend && !redirect_valid && ((sb.size() < DEPTH) || mpop);
        @(posedge clock);
        if (reset) begin
            sb.delete();
            m_pc = START;
        end else if (redirect_valid) begin
            sb.delete();
            m_pc = {redirect_pc[31:2], 2'b00};
        end else begin
            if (mpop) void'(sb.pop_front());
            if (mpush) begin
                sb.push_back('{pc: m_pc, insn: {16'h0000, m_pc[15:0]}});
                m_pc = m_pc + 32'd4;
            end
        end
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        run(n);
        reset = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        cycle();
        redirect_valid = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        m_pc           = START;

        // Reset: outputs are unknown until the first reset edge, so the model is not compared yet.
        do_reset(2);
        chk_en = 1'b1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_pc", out_pc, 32'd0);
        check("rst_insn", out_insn, 32'd0);
        check("rst_end", 32'(fetch_end), 32'd0);
        check("rst_addr", ic_address, START);

        // Free run: one entry per cycle after a single cycle of latency.
        fetch_en  = 1'b1;
        out_ready = 1'b1;
        cycle();
        check("first_valid", 32'(out_valid), 32'd1);
        check("first_pc", out_pc, START);
        check("first_insn", out_insn, 32'h0000_0000);
        run(8);

        // Backpressure fill from a fresh reset.
        do_reset(1);
        out_ready = 1'b0;
        run(10);
        check("bp_addr", ic_address, START + 32'h10);
        check("bp_pc", out_pc, START);
        out_ready = 1'b1;
        run(7);

        // Full queue with one simultaneous push and pop.
        out_ready = 1'b0;
        run(6);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        cycle();

        // Redirect while full and popping.
        out_ready = 1'b1;
        redirect(32'h8002_0103);
        check("rd_valid0", 32'(out_valid), 32'd0);
        check("rd_addr", ic_address, 32'h8002_0100);
        cycle();
        check("rd_valid1", 32'(out_valid), 32'd1);
        check("rd_pc", out_pc, 32'h8002_0100);
        run(3);

        // Fetch disabled: the queue drains and the address holds.
        fetch_en = 1'b0;
        run(5);
        fetch_en = 1'b1;

        // Image end and below-base boundary.
        out_ready = 1'b0;
        redirect(START + 32'd99996);
        cycle();
        check("end_pc", out_pc, 32'h8003_869C);
        run(3);
        check("end_flag", 32'(fetch_end), 32'd1);
        check("end_addr", ic_address, 32'h8003_86A0);
        out_ready = 1'b1;
        run(2);
        redirect(32'h0000_0010);
        check("low_flag", 32'(fetch_end), 32'd1);
        run(2);
        redirect(START);
        check("clr_flag", 32'(fetch_end), 32'd0);
        run(3);

        // Reset mid-stream with three entries queued.
        out_ready = 1'b0;
        redirect(32'h8002_0200);
        run(3);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("mrst_valid", 32'(out_valid), 32'd0);
        check("mrst_addr", ic_address, START);
        check("mrst_pc", out_pc, 32'd0);
        out_ready = 1'b1;
        run(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
